// File: rtl/tm1638_pkg.sv
// Shared TM1638 definitions: word layout, command bytes, frame length,
// sequencer state encoding and the display snapshot record.
package tm1638_pkg;

  localparam int WORD_W       = 18;
  localparam int HAS_DATA_BIT = 16;
  localparam int CMD_LSB      = 8;
  localparam int DATA_LSB     = 0;

  localparam logic [7:0] CMD_WRITE_FIXED = 8'h44;
  localparam logic [7:0] CMD_ADDR        = 8'hC0;
  localparam logic [7:0] CMD_DISP        = 8'h80;

  localparam int FRAME_WORDS = 18;
  localparam int WORD_IDX_W  = 5;

  // Encoding is also used when decoding diagnostic state captures.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  typedef struct packed {
    logic [63:0] digits;
    logic [7:0]  leds;
    logic [2:0]  brightness;
    logic        display_on;
  } snapshot_t;

  // Assemble one word; the data byte is forced to zero for command-only words.
  function automatic logic [WORD_W-1:0] make_word(input logic       has_data,
                                                  input logic [7:0] cmd,
                                                  input logic [7:0] data);
    logic [WORD_W-1:0] w;
    w                   = '0;
    w[HAS_DATA_BIT]     = has_data;
    w[CMD_LSB +: 8]     = cmd;
    w[DATA_LSB +: 8]    = has_data ? data : 8'h00;
    return w;
  endfunction

endpackage

// File: rtl/tm1638_frame_seq_if.sv
// Word link between the frame sequencer (master) and the serialiser (slave).
interface tm1638_frame_seq_if;
  import tm1638_pkg::*;

  logic              busy;
  logic              data_ready;
  logic [WORD_W-1:0] data;

  modport master (input busy, output data_ready, output data);
  modport slave  (output busy, input data_ready, input data);
endinterface

// File: rtl/tm1638_word_mux.sv
// Maps a word index plus a display snapshot onto the 18-bit frame word.
module tm1638_word_mux
  import tm1638_pkg::*;
(
  input  logic [WORD_IDX_W-1:0] i_Word_Idx,
  input  snapshot_t             i_Snap,
  output logic [WORD_W-1:0]     o_Word
);

  // Data byte for each display address: even addresses carry a digit,
  // odd addresses carry one LED in bit 0.
  logic [7:0] addr_data [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_addr
    if (gi % 2 == 0) begin : g_digit
      assign addr_data[gi] = i_Snap.digits[8*(gi/2) +: 8];
    end else begin : g_led
      assign addr_data[gi] = {7'b0, i_Snap.leds[gi/2]};
    end
  end

  logic [3:0] addr;

  // Select the header, one of the 16 address words, or the display-control trailer.
  always_comb begin
    addr   = 4'(i_Word_Idx - WORD_IDX_W'(1));
    o_Word = '0;
    if (i_Word_Idx == '0) begin
      o_Word = make_word(1'b0, CMD_WRITE_FIXED, 8'h00);
    end else if (i_Word_Idx <= WORD_IDX_W'(16)) begin
      o_Word = make_word(1'b1, CMD_ADDR | {4'b0, addr}, addr_data[addr]);
    end else if (i_Word_Idx == WORD_IDX_W'(FRAME_WORDS - 1)) begin
      o_Word = make_word(1'b0, CMD_DISP | {4'b0, i_Snap.display_on, i_Snap.brightness}, 8'h00);
    end
  end

endmodule

// File: rtl/tm1638_frame_seq.sv
// Snapshots the display inputs and streams one 18-word TM1638 refresh frame
// to the serialiser, one word per busy handshake. Frames start on request,
// on a collapsed pending request, or from the optional refresh timer.
module tm1638_frame_seq
  import tm1638_pkg::*;
#(
  parameter int REFRESH_CYCLES = 0
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Update,
  input  logic [63:0]        i_Digits,
  input  logic [7:0]         i_Leds,
  input  logic [2:0]         i_Brightness,
  input  logic               i_Display_On,
  tm1638_frame_seq_if.master spi_link,
  output logic               o_Frame_Busy,
  output logic               o_Frame_Done
);

  // The timer is reloaded in LOAD and expires at zero, so the reload value
  // is two less than the period to give exactly REFRESH_CYCLES between LOADs.
  localparam bit AUTO_REFRESH = (REFRESH_CYCLES > 0);
  localparam int TIMER_W      = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int RELOAD_INT   = (REFRESH_CYCLES > 1) ? REFRESH_CYCLES - 2 : 0;
  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(RELOAD_INT);

  state_e                  state_q, state_d;
  logic [WORD_IDX_W-1:0]   word_idx_q, word_idx_d;
  logic                    pending_q, pending_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  snapshot_t               snap_q, snap_d;

  logic                    timer_expired;
  logic                    trigger;
  logic                    last_word;
  logic [WORD_W-1:0]       word;

  // Expiry is ignored in LOAD because the timer reloads there.
  assign timer_expired = AUTO_REFRESH && (timer_q == '0) && (state_q != ST_LOAD);
  assign trigger       = i_Update || pending_q || timer_expired;
  assign last_word     = (word_idx_q == WORD_IDX_W'(FRAME_WORDS - 1));

  tm1638_word_mux u_word_mux (
    .i_Word_Idx (word_idx_q),
    .i_Snap     (snap_q),
    .o_Word     (word)
  );

  // State and datapath registers.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      pending_q  <= 1'b0;
      timer_q    <= '0;
      snap_q     <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      pending_q  <= pending_d;
      timer_q    <= timer_d;
      snap_q     <= snap_d;
    end
  end

  // Next-state logic for the frame handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (trigger) state_d = ST_LOAD;
      ST_LOAD:      state_d = ST_ISSUE;
      ST_ISSUE:     if (!spi_link.busy) state_d = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (spi_link.busy) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!spi_link.busy) state_d = last_word ? ST_DONE : ST_ISSUE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Word index, pending request, refresh timer and input snapshot.
  always_comb begin
    word_idx_d = word_idx_q;
    pending_d  = pending_q;
    timer_d    = timer_q;
    snap_d     = snap_q;

    if (state_q == ST_LOAD) begin
      word_idx_d = '0;
    end else if (state_q == ST_WAIT_DONE && !spi_link.busy && !last_word) begin
      word_idx_d = word_idx_q + WORD_IDX_W'(1);
    end

    // Requests outside IDLE collapse into a single pending frame; leaving
    // IDLE for LOAD consumes it.
    if (state_q == ST_IDLE) begin
      if (trigger) pending_d = 1'b0;
    end else if (i_Update || timer_expired) begin
      pending_d = 1'b1;
    end

    if (!AUTO_REFRESH) begin
      timer_d = '0;
    end else if (state_q == ST_LOAD) begin
      timer_d = RELOAD;
    end else if (timer_q != '0) begin
      timer_d = timer_q - TIMER_W'(1);
    end

    if (state_q == ST_LOAD) begin
      snap_d.digits     = i_Digits;
      snap_d.leds       = i_Leds;
      snap_d.brightness = i_Brightness;
      snap_d.display_on = i_Display_On;
    end
  end

  // Outputs: the word is only presented while a word transfer is in flight.
  always_comb begin
    spi_link.data_ready = (state_q == ST_ISSUE) && !spi_link.busy;
    spi_link.data       = '0;
    if (state_q == ST_ISSUE || state_q == ST_WAIT_ACK || state_q == ST_WAIT_DONE) begin
      spi_link.data = word;
    end
    o_Frame_Busy = (state_q != ST_IDLE);
    o_Frame_Done = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_tm1638_frame_seq.sv
// Directed bench with a word scoreboard for tm1638_frame_seq: one instance
// driven by explicit updates, one free-running on the refresh timer.
module tb_tm1638_frame_seq;

  logic        clk;
  logic        rst, rst2;
  logic        upd, upd2;
  logic [63:0] digits;
  logic [7:0]  leds;
  logic [2:0]  br;
  logic        on;
  logic        fb1, fd1, fb2, fd2;

  tm1638_frame_seq_if link1 ();
  tm1638_frame_seq_if link2 ();

  tm1638_frame_seq #(.REFRESH_CYCLES(0)) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Update     (upd),
    .i_Digits     (digits),
    .i_Leds       (leds),
    .i_Brightness (br),
    .i_Display_On (on),
    .spi_link     (link1),
    .o_Frame_Busy (fb1),
    .o_Frame_Done (fd1)
  );

  tm1638_frame_seq #(.REFRESH_CYCLES(400)) dut_refresh (
    .i_Clk        (clk),
    .i_Rst        (rst2),
    .i_Update     (upd2),
    .i_Digits     (digits),
    .i_Leds       (leds),
    .i_Brightness (br),
    .i_Display_On (on),
    .spi_link     (link2),
    .o_Frame_Busy (fb2),
    .o_Frame_Done (fd2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;
  int          n_acc   = 0;
  int          done_cnt = 0;
  int          busy_len  = 4;
  int          busy_len2 = 4;
  bit          busy_force = 1'b0;
  logic [17:0] sb[$];
  logic [17:0] obs_log[$];
  int          rise_t[$];
  int          fall_t[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference for one frame word.
  function automatic logic [17:0] exp_word(input int w, input logic [63:0] d,
                                           input logic [7:0] l, input logic [2:0] b,
                                           input logic dispon);
    int         a;
    logic [7:0] byte_v;
    logic [3:0] a4;
    if (w == 0) return {2'b00, 8'h44, 8'h00};
    if (w == 17) return {2'b00, 4'h8, dispon, b, 8'h00};
    a  = w - 1;
    a4 = 4'(a);
    if (a % 2 == 0) byte_v = d[8*(a/2) +: 8];
    else            byte_v = {7'b0, l[a/2]};
    return {2'b01, 4'hC, a4, byte_v};
  endfunction

  task automatic push_frame();
    for (int w = 0; w < 18; w++) sb.push_back(exp_word(w, digits, leds, br, on));
  endtask

  task automatic pulse_update();
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    check("frame_done_count", 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_acc(input int target);
    int k;
    k = 0;
    while (n_acc < target && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("accept_count_reached", 32'(n_acc), 32'(target));
  endtask

  // Serialiser model for the main instance: accepts a word when data_ready is
  // seen, raises busy the following cycle for busy_len cycles, scores words.
  initial begin : spi_model1
    int          cnt;
    bit          accepted;
    bit          prev_ready;
    bit          busy_int;
    logic [17:0] exp;
    cnt = 0; accepted = 0; prev_ready = 0; busy_int = 0;
    link1.busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0; accepted = 0; busy_int = 0;
      end else if (accepted) begin
        busy_int = 1; cnt = busy_len; accepted = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) busy_int = 0;
      end
      link1.busy = busy_int | busy_force;
      #1;
      if (link1.data_ready === 1'b1) begin
        check("ready_while_busy", 32'(link1.busy), 32'h0);
        check("ready_back_to_back", 32'(prev_ready), 32'h0);
        if (sb.size() == 0) begin
          check("word_unexpected_queue_size", 32'(sb.size()), 32'h1);
        end else begin
          exp = sb.pop_front();
          check("word", 32'(link1.data), 32'(exp));
        end
        $display("word %0d accepted: %05h", n_acc, link1.data);
        obs_log.push_back(link1.data);
        n_acc++;
        accepted = 1;
      end
      prev_ready = (link1.data_ready === 1'b1);
    end
  end

  // Serialiser model for the auto-refresh instance.
  initial begin : spi_model2
    int cnt;
    bit accepted;
    bit busy_int;
    cnt = 0; accepted = 0; busy_int = 0;
    link2.busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst2) begin
        cnt = 0; accepted = 0; busy_int = 0;
      end else if (accepted) begin
        busy_int = 1; cnt = busy_len2; accepted = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) busy_int = 0;
      end
      link2.busy = busy_int;
      #1;
      if (link2.data_ready === 1'b1) accepted = 1;
    end
  end

  initial begin : done_monitor
    forever begin
      @(negedge clk);
      if (fd1 === 1'b1) done_cnt++;
    end
  end

  initial begin : refresh_monitor
    bit prev;
    int cyc;
    prev = 0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (fb2 === 1'b1 && !prev) rise_t.push_back(cyc);
      if (fb2 !== 1'b1 && prev)  fall_t.push_back(cyc);
      prev = (fb2 === 1'b1);
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int k;
    rst = 1'b1; rst2 = 1'b1; upd = 1'b0; upd2 = 1'b0;
    digits = '0; leds = '0; br = '0; on = 1'b0;

    // Reset state
    #1;
    check("rst_data_ready", 32'(link1.data_ready), 32'h0);
    check("rst_data", 32'(link1.data), 32'h0);
    check("rst_frame_busy", 32'(fb1), 32'h0);
    check("rst_frame_done", 32'(fd1), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("idle_data_ready", 32'(link1.data_ready), 32'h0);
    check("idle_data", 32'(link1.data), 32'h0);
    check("idle_frame_busy", 32'(fb1), 32'h0);
    check("idle_frame_done", 32'(fd1), 32'h0);
    check("idle_no_words", 32'(n_acc), 32'h0);

    // Frame 1: reference pattern and request latency
    @(negedge clk);
    digits = 64'h0706050403020100; leds = 8'hA5; br = 3'd7; on = 1'b1;
    push_frame();
    pulse_update();
    #1;
    check("load_frame_busy", 32'(fb1), 32'h1);
    check("load_no_ready", 32'(link1.data_ready), 32'h0);
    @(negedge clk);
    #1;
    check("issue_first_ready", 32'(link1.data_ready), 32'h1);
    wait_done(1);
    check("frame1_word_count", 32'(obs_log.size()), 32'd18);
    if (obs_log.size() == 18) begin
      check("frame1_word0", 32'(obs_log[0]), 32'h04400);
      check("frame1_word1", 32'(obs_log[1]), 32'h1C000);
      check("frame1_word2", 32'(obs_log[2]), 32'h1C101);
      check("frame1_word3", 32'(obs_log[3]), 32'h1C201);
      check("frame1_word4", 32'(obs_log[4]), 32'h1C300);
      check("frame1_word17", 32'(obs_log[17]), 32'h08F00);
    end
    check("frame1_sb_empty", 32'(sb.size()), 32'h0);

    // Frame 2: busy held high for 30 cycles ahead of word 5
    obs_log.delete(); n_acc = 0;
    digits = 64'h3F065B4F666D7D07; leds = 8'h3C; br = 3'd2; on = 1'b0;
    push_frame();
    pulse_update();
    wait_acc(5);
    busy_force = 1'b1;
    repeat (30) @(negedge clk);
    check("busy_hold_no_issue", 32'(n_acc), 32'd5);
    busy_force = 1'b0;

    // Request placed in the DONE cycle starts the next frame right after IDLE
    k = 0;
    while (fd1 !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("frame2_done_seen", 32'(fd1), 32'h1);
    digits = 64'h1122334455667788; leds = 8'h81; br = 3'd4; on = 1'b1;
    push_frame();
    pulse_update();
    check("after_done_idle", 32'(fb1), 32'h0);
    @(negedge clk);
    check("pending_restart_load", 32'(fb1), 32'h1);
    wait_done(3);
    check("frame3_sb_empty", 32'(sb.size()), 32'h0);

    // Three requests mid-frame with changed inputs: old snapshot, then one more frame
    n_acc = 0;
    digits = 64'hDEADBEEFCAFEF00D; leds = 8'h5A; br = 3'd1; on = 1'b1;
    push_frame();
    pulse_update();
    wait_acc(3);
    digits = 64'h0123456789ABCDEF; leds = 8'hF0; br = 3'd6; on = 1'b0;
    push_frame();
    pulse_update();
    repeat (7) @(negedge clk);
    pulse_update();
    repeat (11) @(negedge clk);
    pulse_update();
    wait_done(5);
    repeat (60) @(negedge clk);
    check("no_extra_frame_done", 32'(done_cnt), 32'd5);
    check("no_extra_frame_busy", 32'(fb1), 32'h0);
    check("collapse_sb_empty", 32'(sb.size()), 32'h0);

    // Reset while waiting on word 9, then a fresh frame from word 0
    n_acc = 0;
    digits = 64'h8877665544332211; leds = 8'h0F; br = 3'd3; on = 1'b1;
    push_frame();
    pulse_update();
    wait_acc(9);
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_data_ready", 32'(link1.data_ready), 32'h0);
    check("midrst_frame_busy", 32'(fb1), 32'h0);
    check("midrst_data", 32'(link1.data), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    obs_log.delete();
    push_frame();
    pulse_update();
    wait_done(6);
    check("restart_word_count", 32'(obs_log.size()), 32'd18);
    if (obs_log.size() > 0) check("restart_word0", 32'(obs_log[0]), 32'h04400);
    check("restart_sb_empty", 32'(sb.size()), 32'h0);

    // Auto-refresh: fixed period with short frames, no gap with long frames
    rst2 = 1'b0;
    k = 0;
    while (rise_t.size() < 3 && k < 1500) begin
      @(negedge clk);
      k++;
    end
    check("refresh_three_frames", 32'(rise_t.size()), 32'd3);
    busy_len2 = 40;
    if (rise_t.size() >= 3) begin
      check("refresh_period_0", 32'(rise_t[1] - rise_t[0]), 32'd400);
      check("refresh_period_1", 32'(rise_t[2] - rise_t[1]), 32'd400);
    end
    k = 0;
    while (rise_t.size() < 5 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check("refresh_five_frames", 32'(rise_t.size()), 32'd5);
    if (rise_t.size() >= 5 && fall_t.size() >= 4) begin
      check("refresh_long_frame", 32'(fall_t[2] - rise_t[2] > 400), 32'h1);
      check("refresh_gap_0", 32'(rise_t[3] - fall_t[2]), 32'd1);
      check("refresh_gap_1", 32'(rise_t[4] - fall_t[3]), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
